// File: rtl/sprite_draw_arbiter.sv
// Round-robin arbiter that shares one sprite drawer between N_REQ game-logic clients.
// Optional BUSY watchdog enabled by defining DRAW_TIMEOUT_EN (default build: no watchdog).
module sprite_draw_arbiter #(
    parameter int N_REQ   = 3,
    parameter int SPR_W   = 3,
    parameter int TIMEOUT = 4096
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [SPR_W*N_REQ-1:0] req_sprite,
    input  logic [9*N_REQ-1:0]     req_x,
    input  logic [8*N_REQ-1:0]     req_y,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       done,
    output logic                   drw_start,
    output logic [SPR_W-1:0]       drw_sprite,
    output logic [8:0]             drw_x,
    output logic [7:0]             drw_y,
    input  logic                   drw_done,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int PW = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 2 || TIMEOUT > 65535) begin : g_param_check
        $error("sprite_draw_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic [PW-1:0] pick;
    logic          found;
    logic          expire;

    // First requester at or above ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[(int'(ptr) + i) % N_REQ]) begin
                found = 1'b1;
                pick  = PW'((int'(ptr) + i) % N_REQ);
            end
        end
    end

    assign busy = (state != IDLE);

`ifdef DRAW_TIMEOUT_EN
    logic [15:0] cnt;

    // Expiry is flagged on the edge where cnt would reach TIMEOUT-1.
    assign expire = (cnt == 16'(TIMEOUT - 2));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= (state == BUSY) && !drw_done && expire;
            if (state == BUSY)
                cnt <= cnt + 16'd1;
            else
                cnt <= '0;
        end
    end
`else
    assign expire      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= '0;
            win        <= '0;
            grant      <= '0;
            done       <= '0;
            drw_start  <= 1'b0;
            drw_sprite <= '0;
            drw_x      <= '0;
            drw_y      <= '0;
        end else begin
            drw_start <= 1'b0;
            done      <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        state      <= START;
                        win        <= pick;
                        grant      <= N_REQ'(1) << pick;
                        drw_start  <= 1'b1;
                        drw_sprite <= req_sprite[SPR_W*pick +: SPR_W];
                        drw_x      <= req_x[9*pick +: 9];
                        drw_y      <= req_y[8*pick +: 8];
                    end
                end
                START: state <= BUSY;
                BUSY: begin
                    if (drw_done || expire) begin
                        state <= DONE;
                        done  <= grant;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    grant <= '0;
                    ptr   <= (win == PW'(N_REQ - 1)) ? '0 : win + PW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
